// File: rtl/memory_map_io.sv
// Hack-style data memory: RAM, screen RAM, buffered keyboard FIFO and status word
// behind one CPU address space, plus a registered display-scan port on screen RAM.
module memory_map_io #(
  parameter int WIDTH     = 16,
  parameter int ADDR_W    = 15,
  parameter int RAM_AW    = 14,
  parameter int SCREEN_AW = 13,
  parameter int KBD_DEPTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic [WIDTH-1:0]     in,
  input  logic [ADDR_W-1:0]    address,
  input  logic                 load,
  input  logic                 rd,
  output logic [WIDTH-1:0]     out,
  input  logic [WIDTH-1:0]     key_code,
  input  logic                 key_valid,
  output logic                 key_ready,
  input  logic                 scan_en,
  output logic [SCREEN_AW-1:0] scan_addr,
  output logic [WIDTH-1:0]     scan_data,
  output logic                 scan_frame,
  output logic                 err
);

  localparam int unsigned R       = 2 ** RAM_AW;
  localparam int unsigned S       = 2 ** SCREEN_AW;
  localparam int unsigned KBD_A   = R + S;
  localparam int unsigned KSTAT_A = R + S + 1;
  localparam int PTR_W            = $clog2(KBD_DEPTH);
  localparam int CNT_W            = $clog2(KBD_DEPTH + 1);

  generate
    if (R + S + 2 > 2 ** ADDR_W) begin : g_map_check
      $error("memory_map_io: RAM + screen + keyboard words do not fit in ADDR_W");
    end
    if ((KBD_DEPTH < 2) || ((KBD_DEPTH & (KBD_DEPTH - 1)) != 0)) begin : g_depth_check
      $error("memory_map_io: KBD_DEPTH must be a power of two >= 2");
    end
  endgenerate

  logic [WIDTH-1:0]     r_ram    [R];
  logic [WIDTH-1:0]     r_screen [S];
  logic [WIDTH-1:0]     r_fifo   [KBD_DEPTH];
  logic [PTR_W-1:0]     r_rd_ptr;
  logic [PTR_W-1:0]     r_wr_ptr;
  logic [CNT_W-1:0]     r_count;
  logic                 r_overflow;
  logic [SCREEN_AW-1:0] r_scan_addr;
  logic [WIDTH-1:0]     r_scan_data;
  logic                 r_scan_frame;
  logic                 r_err;

  logic [31:0]          w_addr;
  logic                 w_is_ram;
  logic                 w_is_scr;
  logic                 w_is_kbd;
  logic                 w_is_kstat;
  logic                 w_unmapped;
  logic [RAM_AW-1:0]    w_ram_idx;
  logic [SCREEN_AW-1:0] w_scr_idx;
  logic                 w_full;
  logic                 w_flush;
  logic                 w_push;
  logic                 w_pop;
  logic [WIDTH-1:0]     w_kstat;
  logic [WIDTH-1:0]     w_out;

  assign w_addr     = 32'(address);
  assign w_is_ram   = (w_addr < R);
  assign w_is_scr   = (w_addr >= R) && (w_addr < R + S);
  assign w_is_kbd   = (w_addr == KBD_A);
  assign w_is_kstat = (w_addr == KSTAT_A);
  assign w_unmapped = (w_addr > KSTAT_A);
  assign w_ram_idx  = address[RAM_AW-1:0];
  assign w_scr_idx  = SCREEN_AW'(w_addr - R);

  // A write to either keyboard word flushes the FIFO and outranks push/pop.
  assign w_full    = (r_count == CNT_W'(KBD_DEPTH));
  assign w_flush   = load && (w_is_kbd || w_is_kstat);
  assign key_ready = !w_full && !w_flush;
  assign w_push    = key_valid && key_ready;
  assign w_pop     = rd && w_is_kbd && (r_count != {CNT_W{1'b0}}) && !w_flush;

  // CPU-side memory writes; contents deliberately survive reset.
  always_ff @(posedge clock) begin
    if (load && w_is_ram) begin
      r_ram[w_ram_idx] <= in;
    end
    if (load && w_is_scr) begin
      r_screen[w_scr_idx] <= in;
    end
  end

  // FIFO storage write.
  always_ff @(posedge clock) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= key_code;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else if (w_flush) begin
      r_rd_ptr   <= {PTR_W{1'b0}};
      r_wr_ptr   <= {PTR_W{1'b0}};
      r_count    <= {CNT_W{1'b0}};
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + CNT_W'(1'b1);
      end else if (w_pop && !w_push) begin
        r_count <= r_count - CNT_W'(1'b1);
      end
      if (key_valid && w_full) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Display scan; the nonblocking read gives old data on a same-cycle CPU write.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_scan_addr  <= {SCREEN_AW{1'b0}};
      r_scan_data  <= {WIDTH{1'b0}};
      r_scan_frame <= 1'b0;
    end else if (scan_en) begin
      r_scan_data  <= r_screen[r_scan_addr];
      r_scan_frame <= (r_scan_addr == {SCREEN_AW{1'b1}});
      r_scan_addr  <= r_scan_addr + 1'b1;
    end else begin
      r_scan_frame <= 1'b0;
    end
  end

  // Unmapped-access error pulse.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= (load || rd) && w_unmapped;
    end
  end

  // Keyboard status word: overflow in the MSB, occupancy in the low bits.
  always_comb begin
    w_kstat              = {WIDTH{1'b0}};
    w_kstat[CNT_W-1:0]   = r_count;
    w_kstat[WIDTH-1]     = r_overflow;
  end

  // CPU read mux.
  always_comb begin
    w_out = {WIDTH{1'b0}};
    if (w_is_ram) begin
      w_out = r_ram[w_ram_idx];
    end else if (w_is_scr) begin
      w_out = r_screen[w_scr_idx];
    end else if (w_is_kbd) begin
      w_out = (r_count != {CNT_W{1'b0}}) ? r_fifo[r_rd_ptr] : {WIDTH{1'b0}};
    end else if (w_is_kstat) begin
      w_out = w_kstat;
    end else begin
      w_out = {WIDTH{1'b0}};
    end
  end

  assign out        = w_out;
  assign scan_addr  = r_scan_addr;
  assign scan_data  = r_scan_data;
  assign scan_frame = r_scan_frame;
  assign err        = r_err;

endmodule

// File: tb/tb_memory_map_io.sv
// Directed bench for memory_map_io: vector table for the memory map, hand-written
// sequences for the keyboard FIFO, display scan and reset corner cases.
module tb_memory_map_io;

  localparam logic [14:0] A_KBD   = 15'd24576;
  localparam logic [14:0] A_KSTAT = 15'd24577;
  localparam logic [14:0] A_BAD   = 15'd24580;

  logic        clock = 1'b0;
  logic        reset_n;
  logic [15:0] in;
  logic [14:0] address;
  logic        load;
  logic        rd;
  logic [15:0] out;
  logic [15:0] key_code;
  logic        key_valid;
  logic        key_ready;
  logic        scan_en;
  logic [12:0] scan_addr;
  logic [15:0] scan_data;
  logic        scan_frame;
  logic        err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic        ld;
    logic        rd;
    logic [14:0] addr;
    logic [15:0] din;
    logic        chk;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[11];
  logic [15:0] model_q[$];

  memory_map_io dut (
    .clock(clock), .reset_n(reset_n), .in(in), .address(address), .load(load),
    .rd(rd), .out(out), .key_code(key_code), .key_valid(key_valid),
    .key_ready(key_ready), .scan_en(scan_en), .scan_addr(scan_addr),
    .scan_data(scan_data), .scan_frame(scan_frame), .err(err)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    load = 1'b0; rd = 1'b0; key_valid = 1'b0; in = 16'h0;
  endtask

  task automatic read_chk(input string name, input logic [14:0] a, input logic [15:0] exp);
    address = a;
    #1;
    chk(name, 32'(out), 32'(exp));
  endtask

  initial begin
    int frames;
    int frame_data;
    int mism;
    int bound;
    logic [15:0] head;

    vecs[0]  = '{1'b1, 1'b0, 15'd0,     16'h1234, 1'b0, 16'h0000};
    vecs[1]  = '{1'b1, 1'b0, 15'd16383, 16'hABCD, 1'b0, 16'h0000};
    vecs[2]  = '{1'b1, 1'b0, 15'd16384, 16'h5555, 1'b0, 16'h0000};
    vecs[3]  = '{1'b1, 1'b0, 15'd24575, 16'hAAAA, 1'b0, 16'h0000};
    vecs[4]  = '{1'b0, 1'b0, 15'd0,     16'h0000, 1'b1, 16'h1234};
    vecs[5]  = '{1'b0, 1'b0, 15'd16383, 16'h0000, 1'b1, 16'hABCD};
    vecs[6]  = '{1'b0, 1'b0, 15'd16384, 16'h0000, 1'b1, 16'h5555};
    vecs[7]  = '{1'b0, 1'b0, 15'd24575, 16'h0000, 1'b1, 16'hAAAA};
    vecs[8]  = '{1'b0, 1'b0, A_BAD,     16'h0000, 1'b1, 16'h0000};
    vecs[9]  = '{1'b0, 1'b0, A_KSTAT,   16'h0000, 1'b1, 16'h0000};
    vecs[10] = '{1'b0, 1'b0, A_KBD,     16'h0000, 1'b1, 16'h0000};

    reset_n = 1'b0; idle(); address = 15'd0; key_code = 16'h0; scan_en = 1'b0;
    #12;
    chk("rst_scan_addr", 32'(scan_addr), 32'd0);
    chk("rst_scan_data", 32'(scan_data), 32'd0);
    chk("rst_scan_frame", 32'(scan_frame), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_key_ready", 32'(key_ready), 32'd1);
    read_chk("rst_kstat", A_KSTAT, 16'h0000);
    reset_n = 1'b1;
    tick();

    // memory map vectors
    for (int i = 0; i < 11; i++) begin
      load = vecs[i].ld; rd = vecs[i].rd; address = vecs[i].addr; in = vecs[i].din;
      #1;
      if (vecs[i].chk) chk($sformatf("vec%0d", i), 32'(out), 32'(vecs[i].exp));
      tick();
    end
    idle();

    // unmapped write: one-cycle err, no RAM change
    load = 1'b1; address = A_BAD; in = 16'hFFFF;
    tick();
    idle();
    chk("err_pulse", 32'(err), 32'd1);
    tick();
    chk("err_clear", 32'(err), 32'd0);
    read_chk("ram0_kept", 15'd0, 16'h1234);
    read_chk("ram_top_kept", 15'd16383, 16'hABCD);
    rd = 1'b1; address = A_BAD;
    tick();
    idle();
    chk("err_rd_unmapped", 32'(err), 32'd1);

    // push three codes, then pop them in order
    for (int i = 0; i < 3; i++) begin
      key_valid = 1'b1; key_code = 16'h41 + 16'(i);
      tick();
    end
    idle();
    read_chk("kstat_3", A_KSTAT, 16'h0003);
    for (int i = 0; i < 3; i++) begin
      rd = 1'b1; address = A_KBD;
      #1;
      chk($sformatf("pop%0d", i), 32'(out), 32'h41 + 32'(i));
      tick();
    end
    idle();
    read_chk("kstat_0", A_KSTAT, 16'h0000);
    read_chk("kbd_empty", A_KBD, 16'h0000);

    // fill, overflow, flush
    for (int i = 0; i < 8; i++) begin
      key_valid = 1'b1; key_code = 16'h60 + 16'(i);
      tick();
    end
    key_code = 16'h99;
    #1;
    chk("full_not_ready", 32'(key_ready), 32'd0);
    tick();
    idle();
    read_chk("kstat_ovf", A_KSTAT, 16'h8008);
    read_chk("full_head", A_KBD, 16'h0060);
    load = 1'b1; address = A_KSTAT; in = 16'h0;
    #1;
    chk("flush_blocks_ready", 32'(key_ready), 32'd0);
    tick();
    idle();
    read_chk("kstat_flushed", A_KSTAT, 16'h0000);
    chk("ready_after_flush", 32'(key_ready), 32'd1);

    // simultaneous push+pop with 4 entries, across pointer wrap
    model_q.delete();
    for (int i = 0; i < 4; i++) begin
      key_valid = 1'b1; key_code = 16'h10 + 16'(i);
      model_q.push_back(key_code);
      tick();
    end
    mism = 0;
    for (int i = 0; i < 20; i++) begin
      key_valid = 1'b1; key_code = 16'h50 + 16'(i); rd = 1'b1; address = A_KBD;
      #1;
      head = model_q.pop_front();
      if (out !== head) mism++;
      model_q.push_back(key_code);
      tick();
    end
    idle();
    chk("pushpop_order", 32'(mism), 32'd0);
    read_chk("pushpop_count", A_KSTAT, 16'h0004);
    mism = 0;
    for (int i = 0; i < 4; i++) begin
      rd = 1'b1; address = A_KBD;
      #1;
      head = model_q.pop_front();
      if (out !== head) mism++;
      tick();
    end
    idle();
    chk("drain_order", 32'(mism), 32'd0);

    // fill screen with word = index, then scan a full frame plus two words
    for (int i = 0; i < 8192; i++) begin
      load = 1'b1; address = 15'(16384 + i); in = 16'(i);
      tick();
    end
    idle();
    chk("scan_idle_addr", 32'(scan_addr), 32'd0);
    scan_en = 1'b1;
    frames = 0; frame_data = -1; mism = 0;
    for (int k = 1; k <= 8194; k++) begin
      tick();
      if (scan_data !== 16'((k - 1) % 8192)) mism++;
      if (scan_frame) begin
        frames++;
        frame_data = int'(scan_data);
      end
      if (k == 8192 && scan_addr !== 13'd0) mism++;
    end
    chk("scan_seq", 32'(mism), 32'd0);
    chk("scan_frames", 32'(frames), 32'd1);
    chk("scan_frame_data", 32'(frame_data), 32'd8191);
    chk("scan_wrap_addr", 32'(scan_addr), 32'd2);

    // collision: CPU write while scan reads the same word
    bound = 0;
    while (scan_addr !== 13'd5 && bound < 16) begin
      tick();
      bound++;
    end
    chk("reach_addr5", 32'(scan_addr), 32'd5);
    load = 1'b1; address = 15'(16384 + 5); in = 16'h7777;
    tick();
    idle();
    chk("collide_old", 32'(scan_data), 32'd5);
    for (int k = 0; k < 8192; k++) tick();
    chk("collide_new", 32'(scan_data), 32'h7777);

    // asynchronous reset mid-scan
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    #1;
    chk("async_scan_addr", 32'(scan_addr), 32'd0);
    chk("async_scan_data", 32'(scan_data), 32'd0);
    scan_en = 1'b0;
    #10;
    reset_n = 1'b1;
    tick();
    read_chk("mem_survives_rst", 15'd16383, 16'hABCD);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/memory_map_io.md
Name: memory_map_io

Overview:
Parametrised Hack-style data-memory system. It decodes one CPU address space into four regions: data RAM, screen RAM, a buffered keyboard FIFO, and a keyboard status register. It adds a registered display-scan read port on screen RAM and an error flag for unmapped accesses. It sits between the CPU data port (in/address/load/out) and the keyboard and display front ends.

Parameters:
WIDTH, 16, data word width
ADDR_W, 15, CPU address width
RAM_AW, 14, data RAM address width (2**RAM_AW words)
SCREEN_AW, 13, screen RAM address width (2**SCREEN_AW words)
KBD_DEPTH, 8, keyboard FIFO depth (power of two, >=2)

Ports:
clock  in  1  system clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
in  in  WIDTH  CPU write data
address  in  ADDR_W  CPU address
load  in  1  CPU write enable
rd  in  1  CPU read strobe (pops keyboard FIFO)
out  out  WIDTH  CPU read data (combinational)
key_code  in  WIDTH  keyboard scan code
key_valid  in  1  key_code valid
key_ready  out  1  FIFO can accept key_code
scan_en  in  1  advance display scan
scan_addr  out  SCREEN_AW  current scan word address
scan_data  out  WIDTH  registered screen word
scan_frame  out  1  pulse: scan_data holds last word of frame
err  out  1  one-cycle pulse: unmapped access

Behaviour:
- Map: RAM = [0, R), R = 2**RAM_AW. SCREEN = [R, R+S), S = 2**SCREEN_AW. KBD = R+S. KSTAT = R+S+1. Everything above is unmapped. Defaults: 0-16383, 16384-24575, 24576, 24577, 24578-32767.
- Elaborate-time check: R+S+2 <= 2**ADDR_W.
- Reset (reset_n=0, async): FIFO empty, overflow=0, scan_addr=0, scan_data=0, scan_frame=0, err=0. RAM and screen contents are not reset.
- out is combinational, zero latency:
  - RAM/SCREEN: stored word.
  - KBD: FIFO head, or 0 if empty.
  - KSTAT: {overflow, zeros, count}, with count in the low bits (clog2(KBD_DEPTH+1) bits).
  - Unmapped: 0.
- Writes: load=1 in RAM/SCREEN stores `in` at the edge. A later read of the same address sees the new value.
  - load=1 at KBD or KSTAT = flush: count:=0, overflow:=0.
  - load=1 at an unmapped address is ignored.
- FIFO push: key_valid && key_ready at the edge. key_ready = (count<KBD_DEPTH) && !flush_this_cycle.
- Overflow: key_valid while full sets overflow (sticky). The code is dropped.
- Pop: rd=1 && address==KBD && count>0 removes the head at the edge. rd on an empty FIFO has no effect. rd at other addresses has no side effect.
- Simultaneous push+pop (non-empty, not full): count unchanged, order preserved.
- Push into empty + pop in same cycle: pop ignored, push accepted.
- Flush has priority over push and pop in the same cycle.
- Pointers wrap modulo KBD_DEPTH.
- Scan port, when scan_en=1 at an edge:
  - scan_data <= screen[scan_addr].
  - scan_frame <= (scan_addr == S-1).
  - scan_addr <= scan_addr+1, wrapping S-1 to 0.
- When scan_en=0: scan_addr and scan_data hold, scan_frame <= 0.
- CPU write to the same screen word in the same cycle as a scan read: scan_data gets the old value (read-before-write).
- err <= 1 for one cycle after any edge where (load || rd) and the address is unmapped; otherwise 0.
- reset_n asserted mid-operation: FIFO contents are discarded immediately; memories keep their data.

Test Plan:
- Reset, then write 16'h1234 to 0, 16'hABCD to 16383, 16'h5555 to 16384, 16'hAAAA to 24575 -> reads return the same values. Read 24580 -> out=0. load at 24580 -> err=1 for exactly one cycle, no RAM word changed.
- Push 3 codes 0x41,0x42,0x43 -> KSTAT=3. Three rd pops at 24576 -> out 0x41,0x42,0x43 in order, then KSTAT=0 and KBD reads 0.
- Push 8 codes, then hold key_valid with 0x99 -> key_ready=0, KSTAT=16'h8008. Write 0 to 24577 -> KSTAT=0, key_ready=1.
- With 4 entries, push 0x50 and pop in the same cycle -> count stays 4, head advances. Repeat 20 times -> FIFO order is correct across pointer wrap.
- Fill screen with word=index, hold scan_en=1 for 8192+2 cycles:
  - scan_data follows addr 0,1,... with 1-cycle latency.
  - scan_frame pulses once, with data 8191.
  - scan_addr wraps to 0.
- Write 16'h7777 to screen word 5 in the cycle scan_addr=5 (old value 5) -> scan_data=5 at that edge, next frame returns 16'h7777. Assert reset_n=0 mid-scan -> scan_addr=0 and scan_data=0 asynchronously.
